seg7_scan: RTL and testbench

Four-digit multiplexed display scanner that sits directly upstream of the single-digit hex-to-7-segment decoder. It holds a 16-bit value and cycles through its four nibbles at a programmable refresh rate. For each digit it drives the selected nibble onto the decoder's `w,x,y,z` inputs and asserts the matching active-low anode. It provides tear-free value updates at frame boundaries, one dead (all-anodes-off) cycle per digit change, and optional leading-zero blanking.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_tick.sv | 52 +++++
 rtl/seg7_scan.sv | 156 +++++++++++++++
 tb/tb_seg7_scan.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the multiplexed 7-segment display scanner.
//   SEG7_DIGITS  : number of multiplexed digits
//   SEG7_NIB_W   : width of one hex digit
//   SEG7_AN_OFF  : active-low anode pattern with every digit dark
//   an_onehot_n  : active-low one-hot anode pattern for a digit index
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG7_DIGITS = 4;
    localparam int SEG7_NIB_W  = 4;
    localparam logic [SEG7_DIGITS-1:0] SEG7_AN_OFF = 4'b1111;

    // Active-low anode word that lights only digit idx.
    function automatic logic [SEG7_DIGITS-1:0] an_onehot_n(input logic [1:0] idx);
        an_onehot_n = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_tick.sv
// -----------------------------------------------------------------------------
// seg7_tick
// Free-running prescaler that counts enabled clocks and raises tick for the
// single clock in which the count sits at DIV-1; the count then restarts at 0.
// While enable is low the count holds and tick stays low. Reusable for
// debounce and blink timers.
//   clk    in  : system clock
//   rst    in  : synchronous active-high reset
//   enable in  : count enable
//   tick   out : combinational terminal-count strobe (enable && cnt == DIV-1)
// -----------------------------------------------------------------------------
module seg7_tick #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_s;

    // Terminal-count detect and next count value.
    always_comb begin
        tick_s = enable && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        if (tick_s) begin
            cnt_d = {CW{1'b0}};
        end else if (enable) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Four-digit multiplexed display scanner feeding a single hex-to-7-segment
// decoder. Cycles through the four nibbles of a held 16-bit value, with one
// dark cycle at every digit change, tear-free updates at frame boundaries and
// optional leading-zero blanking.
//   clk        in  : system clock
//   rst        in  : synchronous active-high reset
//   enable     in  : 1 = scanning, 0 = display dark and scan frozen
//   load       in  : one-cycle strobe capturing value
//   value      in  : [15:0] value to display, value[3:0] is digit 0
//   blank_lz   in  : 1 = blank leading zero digits
//   w,x,y,z    out : current nibble bits 3..0 to the decoder
//   an         out : [3:0] active-low anodes, an[k] = digit k
//   frame_done out : one-cycle pulse after the digit 3 -> digit 0 wrap
// -----------------------------------------------------------------------------
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   load,
    input  logic [15:0]            value,
    input  logic                   blank_lz,
    output logic                   w,
    output logic                   x,
    output logic                   y,
    output logic                   z,
    output logic [SEG7_DIGITS-1:0] an,
    output logic                   frame_done
);

    logic                   tick_s;
    logic                   boundary_s;
    logic                   blank_s;
    logic [SEG7_NIB_W-1:0]  digit_s;

    logic [1:0]             idx_q,        idx_d;
    logic [15:0]            shadow_q,     shadow_d;
    logic [15:0]            pending_q,    pending_d;
    logic                   pend_v_q,     pend_v_d;
    logic [SEG7_NIB_W-1:0]  nib_q,        nib_d;
    logic [SEG7_DIGITS-1:0] an_q,         an_d;
    logic                   frame_done_q, frame_done_d;

    seg7_tick #(
        .DIV    (REFRESH_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick_s)
    );

    // Current digit nibble and leading-zero blank decision from the shadow.
    always_comb begin
        digit_s = 4'h0;
        blank_s = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_s = shadow_q[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                digit_s = shadow_q[7:4];
                blank_s = blank_lz && (shadow_q[15:4] == 12'h000);
            end
            2'd2: begin
                digit_s = shadow_q[11:8];
                blank_s = blank_lz && (shadow_q[15:8] == 8'h00);
            end
            2'd3: begin
                digit_s = shadow_q[15:12];
                blank_s = blank_lz && (shadow_q[15:12] == 4'h0);
            end
            default: begin
                digit_s = 4'h0;
                blank_s = 1'b0;
            end
        endcase
    end

    // Scan index, staged-load handling and output next-state.
    always_comb begin
        boundary_s   = tick_s && (idx_q == 2'd3);
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_v_d     = pend_v_q;
        frame_done_d = boundary_s;
        nib_d        = digit_s;
        an_d         = SEG7_AN_OFF;

        if (tick_s) begin
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end

        // A direct load (dark display or boundary) wins over any staged value.
        if (load && (!enable || boundary_s)) begin
            shadow_d = value;
            pend_v_d = 1'b0;
        end else if (load) begin
            pending_d = value;
            pend_v_d  = 1'b1;
        end else if (boundary_s && pend_v_q) begin
            shadow_d = pending_q;
            pend_v_d = 1'b0;
        end else begin
            shadow_d = shadow_q;
        end

        // The tick edge is the dead cycle: anodes go dark while nib still
        // holds the outgoing digit, so no ghosting onto the next digit.
        if (!enable || tick_s) begin
            an_d = SEG7_AN_OFF;
        end else if (blank_s) begin
            an_d = SEG7_AN_OFF;
        end else begin
            an_d = an_onehot_n(idx_q);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            pending_q    <= 16'h0000;
            pend_v_q     <= 1'b0;
            nib_q        <= 4'h0;
            an_q         <= SEG7_AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            nib_q        <= nib_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign w          = nib_q[3];
    assign x          = nib_q[2];
    assign y          = nib_q[1];
    assign z          = nib_q[0];
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan
// Directed bench for seg7_scan with REFRESH_DIV = 4 (4 clocks per digit,
// 16 clocks per frame). Inputs change on the falling edge; outputs are
// checked on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        blank_lz = 1'b0;
    logic        w, x, y, z;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic        blz;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        fd;
    } vec_t;

    vec_t tbl[17];

    seg7_scan #(
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .w          (w),
        .x          (x),
        .y          (y),
        .z          (z),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge happen, then compare.
    task automatic apply(input logic r, input logic en, input logic ld,
                         input logic [15:0] v, input logic bz,
                         input logic [3:0] e_an, input logic [3:0] e_nib,
                         input logic e_fd, input string nm, input int step);
        rst      = r;
        enable   = en;
        load     = ld;
        value    = v;
        blank_lz = bz;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({an, w, x, y, z, frame_done} !== {e_an, e_nib, e_fd}) begin
            errors++;
            $display("FAIL %s step %0d: got an=%b nib=%h fd=%b, expected an=%b nib=%h fd=%b",
                     nm, step, an, {w, x, y, z}, frame_done, e_an, e_nib, e_fd);
        end
    endtask

    // One full enabled frame starting at digit 0 / count 0, with up to two
    // loads at edges la and lb (1..16, 0 = none).
    task automatic run_frame(input logic [15:0] shown, input logic bz,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input string nm);
        for (int i = 1; i <= 16; i++) begin
            int          d;
            int          c;
            logic        ld;
            logic [15:0] v;
            logic [15:0] upper;
            logic        blanked;
            logic [3:0]  e_an;
            logic [3:0]  e_nib;
            logic [3:0]  one;
            d       = (i - 1) / 4;
            c       = (i - 1) % 4;
            ld      = (i == la) || (i == lb);
            v       = (i == la) ? va : vb;
            upper   = shown >> (4 * d);
            blanked = bz && (d != 0) && (upper == 16'h0000);
            e_nib   = upper[3:0];
            one     = 4'b0001;
            e_an    = (c == 3 || blanked) ? 4'b1111 : ~(one << d);
            apply(1'b0, 1'b1, ld, v, bz, e_an, e_nib, (i == 16), nm, i);
        end
    endtask

    logic [3:0] pre_an[10];

    initial begin
        // Reset (dominating an asserted load) then one frame with no value.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 4'b1111, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1110, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1110, 4'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1110, 4'h0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1111, 4'h0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1101, 4'h0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1101, 4'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1101, 4'h0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1111, 4'h0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1011, 4'h0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1011, 4'h0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1011, 4'h0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1111, 4'h0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0111, 4'h0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0111, 4'h0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0111, 4'h0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1111, 4'h0, 1'b1};

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].val, tbl[i].blz,
                  tbl[i].an, tbl[i].nib, tbl[i].fd, "reset_scan", i);
        end

        // Second empty frame: frame_done spacing is 16.
        run_frame(16'h0000, 1'b0, 0, 16'h0000, 0, 16'h0000, "idle_frame");

        // Mid-frame load is held back until the boundary.
        run_frame(16'h0000, 1'b0, 2, 16'hA3C5, 0, 16'h0000, "load_staged");
        run_frame(16'hA3C5, 1'b0, 3, 16'h1111, 9, 16'h2222, "show_a3c5");
        run_frame(16'h2222, 1'b0, 5, 16'h1111, 16, 16'h7E81, "last_load_wins");
        // Boundary load beat the staged 1111 and cleared it.
        run_frame(16'h7E81, 1'b0, 0, 16'h0000, 0, 16'h0000, "boundary_load");
        run_frame(16'h7E81, 1'b1, 6, 16'h0040, 0, 16'h0000, "no_stale_pend");

        // Leading-zero blanking.
        run_frame(16'h0040, 1'b1, 10, 16'h0000, 0, 16'h0000, "blank_0040");
        run_frame(16'h0000, 1'b1, 0, 16'h0000, 0, 16'h0000, "blank_0000");

        // Enable dropped mid digit 2, load while dark, resume.
        pre_an = '{4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101,
                   4'b1101, 4'b1101, 4'b1111, 4'b1011, 4'b1011};
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, pre_an[i], 4'h0, 1'b0, "pre_disable", i);
        end
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, (i == 9), 16'hFFFF, 1'b0, 4'b1111, 4'h0, 1'b0, "disabled", i);
        end
        apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1011, 4'hF, 1'b0, "resume", 1);
        apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1111, 4'hF, 1'b0, "resume", 2);
        apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0111, 4'hF, 1'b0, "resume", 3);
        apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0111, 4'hF, 1'b0, "resume", 4);
        apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0111, 4'hF, 1'b0, "resume", 5);
        apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1111, 4'hF, 1'b1, "resume", 6);

        // Reset mid-frame with a staged value pending.
        apply(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 4'b1110, 4'hF, 1'b0, "pre_reset", 1);
        apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1110, 4'hF, 1'b0, "pre_reset", 2);
        apply(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1110, 4'hF, 1'b0, "pre_reset", 3);
        apply(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b1111, 4'h0, 1'b0, "mid_reset", 4);
        run_frame(16'h0000, 1'b0, 0, 16'h0000, 0, 16'h0000, "after_reset1");
        run_frame(16'h0000, 1'b0, 0, 16'h0000, 0, 16'h0000, "after_reset2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
